// File: rtl/ff_input_pkg.sv
// Shared constants for the foodfight control front end: sw bus bit
// positions, the released/idle sw pattern and the attract-mode FSM encoding.
package ff_input_pkg;

  localparam int SW_W       = 12;

  localparam int SW_JS_D    = 11;
  localparam int SW_JS_U    = 10;
  localparam int SW_JS_R    = 9;
  localparam int SW_JS_L    = 8;
  localparam int SW_COIN1   = 7;
  localparam int SW_COIN2   = 6;
  localparam int SW_START1  = 5;
  localparam int SW_START2  = 4;
  localparam int SW_COINAUX = 3;
  localparam int SW_THROW1  = 2;
  localparam int SW_THROW2  = 1;
  localparam int SW_TEST    = 0;

  // Joystick idle low, every button released (active-low on the bus)
  localparam logic [SW_W-1:0] SW_IDLE = 12'h0FF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AUTO_WAIT = 3'd1,
    ST_COIN      = 3'd2,
    ST_GAP1      = 3'd3,
    ST_START     = 3'd4,
    ST_GAP2      = 3'd5,
    ST_PLAY      = 3'd6,
    ST_HALT      = 3'd7
  } auto_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ff_debounce.sv
// Two-flop synchroniser followed by a hold-steady debouncer. The output only
// follows the synchronised input after it has differed for DB_CYCLES
// consecutive cycles; DB_CYCLES=1 degenerates to a plain synchroniser
// plus one register.
module ff_debounce #(
  parameter int DB_CYCLES = 120000
) (
  input  logic clk12m,
  input  logic reset_n,
  input  logic d_async,
  output logic q
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Metastability guard on the raw pin
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= d_async;
      sync2 <= sync1;
    end
  end

  // Count how long the synced value has disagreed with q; accept it once stable long enough
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (sync2 == q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      q   <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ff_input_ctrl.sv
// Player-control front end for foodfight: debounces board buttons and
// joystick, runs the attract-mode auto-play sequencer and drives the
// registered 12-bit sw bus of ff_top. Any manual press during auto-play
// hands control back to the player until auto_en is dropped.
module ff_input_ctrl
  import ff_input_pkg::*;
#(
  parameter int DB_CYCLES    = 120000,
  parameter int AUTO_DELAY   = 36000000,
  parameter int PULSE_CYCLES = 1200000,
  parameter int GAP_CYCLES   = 12000000,
  parameter int THROW_PERIOD = 6000000
) (
  input  logic            clk12m,
  input  logic            reset_n,
  input  logic            button1,
  input  logic            button2,
  input  logic            button3,
  input  logic [3:0]      js_raw,
  input  logic            auto_en,
  output logic [SW_W-1:0] sw,
  output logic            auto_active
);

  localparam int MAXP = max_int(max_int(AUTO_DELAY, PULSE_CYCLES),
                                max_int(GAP_CYCLES, THROW_PERIOD));
  localparam int CTW  = (MAXP > 1) ? $clog2(MAXP) : 1;

  // The shared counter holds "cycles left in this state minus one", so each
  // state lasts exactly its parameter in cycles.
  localparam logic [CTW-1:0] LD_DELAY  = CTW'(AUTO_DELAY - 1);
  localparam logic [CTW-1:0] LD_PULSE  = CTW'(PULSE_CYCLES - 1);
  localparam logic [CTW-1:0] LD_GAP    = CTW'(GAP_CYCLES - 1);
  localparam logic [CTW-1:0] LD_PERIOD = CTW'(THROW_PERIOD - 1);
  localparam logic [CTW-1:0] THROW_ON  = CTW'(THROW_PERIOD - PULSE_CYCLES);

  logic           db_b1;
  logic           db_b2;
  logic           db_b3;
  logic [3:0]     db_js;
  logic           auto_en_s;

  logic [6:0]     db_now;
  logic [6:0]     db_prev;
  logic           rise_any;

  auto_state_t    state;
  auto_state_t    state_nxt;
  logic [CTW-1:0] cnt;
  logic [CTW-1:0] cnt_nxt;

  logic           auto_gate;
  logic           auto_coin;
  logic           auto_start;
  logic           auto_throw;
  logic [SW_W-1:0] sw_nxt;

  ff_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b1 (
    .clk12m(clk12m), .reset_n(reset_n), .d_async(button1), .q(db_b1));
  ff_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b2 (
    .clk12m(clk12m), .reset_n(reset_n), .d_async(button2), .q(db_b2));
  ff_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b3 (
    .clk12m(clk12m), .reset_n(reset_n), .d_async(button3), .q(db_b3));

  for (genvar gi = 0; gi < 4; gi++) begin : g_js
    ff_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_js (
      .clk12m(clk12m), .reset_n(reset_n), .d_async(js_raw[gi]), .q(db_js[gi]));
  end

  // auto_en is a level switch: synchronise only, no debounce
  ff_debounce #(.DB_CYCLES(1)) u_sync_en (
    .clk12m(clk12m), .reset_n(reset_n), .d_async(auto_en), .q(auto_en_s));

  assign db_now   = {db_js, db_b3, db_b2, db_b1};
  assign rise_any = |(db_now & ~db_prev);

  // Previous debounced values for rising-edge detection of manual presses
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) db_prev <= '0;
    else          db_prev <= db_now;
  end

  // Sequencer state and shared down-counter
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: auto_en drop beats a manual override, which beats sequencing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state != ST_IDLE && !auto_en_s) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (state != ST_IDLE && state != ST_HALT && rise_any) begin
      state_nxt = ST_HALT;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (auto_en_s) begin
            state_nxt = ST_AUTO_WAIT;
            cnt_nxt   = LD_DELAY;
          end
        end
        ST_AUTO_WAIT: begin
          if (cnt == '0) begin
            state_nxt = ST_COIN;
            cnt_nxt   = LD_PULSE;
          end else begin
            cnt_nxt = cnt - CTW'(1);
          end
        end
        ST_COIN: begin
          if (cnt == '0) begin
            state_nxt = ST_GAP1;
            cnt_nxt   = LD_GAP;
          end else begin
            cnt_nxt = cnt - CTW'(1);
          end
        end
        ST_GAP1: begin
          if (cnt == '0) begin
            state_nxt = ST_START;
            cnt_nxt   = LD_PULSE;
          end else begin
            cnt_nxt = cnt - CTW'(1);
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            state_nxt = ST_GAP2;
            cnt_nxt   = LD_GAP;
          end else begin
            cnt_nxt = cnt - CTW'(1);
          end
        end
        ST_GAP2: begin
          if (cnt == '0) begin
            state_nxt = ST_PLAY;
            cnt_nxt   = LD_PERIOD;
          end else begin
            cnt_nxt = cnt - CTW'(1);
          end
        end
        ST_PLAY: begin
          if (cnt == '0) cnt_nxt = LD_PERIOD;
          else           cnt_nxt = cnt - CTW'(1);
        end
        ST_HALT: begin
          state_nxt = ST_HALT;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Auto presses; squashed in the very cycle an override or auto_en drop is seen
  always_comb begin
    auto_gate  = auto_en_s & ~rise_any;
    auto_coin  = auto_gate & (state == ST_COIN);
    auto_start = auto_gate & (state == ST_START);
    auto_throw = auto_gate & (state == ST_PLAY) & (cnt >= THROW_ON);
    sw_nxt             = SW_IDLE;
    sw_nxt[SW_JS_D]    = db_js[3];
    sw_nxt[SW_JS_U]    = db_js[2];
    sw_nxt[SW_JS_R]    = db_js[1];
    sw_nxt[SW_JS_L]    = db_js[0];
    sw_nxt[SW_COIN1]   = ~(db_b1 | auto_coin);
    sw_nxt[SW_COIN2]   = 1'b1;
    sw_nxt[SW_START1]  = ~(db_b2 | auto_start);
    sw_nxt[SW_START2]  = 1'b1;
    sw_nxt[SW_COINAUX] = 1'b1;
    sw_nxt[SW_THROW1]  = ~(db_b3 | auto_throw);
    sw_nxt[SW_THROW2]  = 1'b1;
    sw_nxt[SW_TEST]    = 1'b1;
  end

  // Registered sw bus and activity flag
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      sw          <= SW_IDLE;
      auto_active <= 1'b0;
    end else begin
      sw          <= sw_nxt;
      auto_active <= (state >= ST_COIN) && (state <= ST_PLAY);
    end
  end

endmodule

// File: tb/tb_ff_input_ctrl.sv
// Scoreboard bench for ff_input_ctrl with short timing parameters. A
// reference model written in terms of sample history, stable-run lengths
// and a time-since-enable schedule predicts each registered output.
module tb_ff_input_ctrl;
  import ff_input_pkg::*;

  localparam int DB = 4;
  localparam int AD = 20;
  localparam int PC = 3;
  localparam int GC = 5;
  localparam int TP = 8;

  localparam int COIN_T  = AD;
  localparam int START_T = AD + PC + GC;
  localparam int PLAY_T  = START_T + PC + GC;
  localparam logic [11:0] IDLE_SW = 12'h0FF;

  logic        clk12m = 1'b0;
  logic        reset_n = 1'b0;
  logic        button1 = 1'b0;
  logic        button2 = 1'b0;
  logic        button3 = 1'b0;
  logic [3:0]  js_raw = 4'b0;
  logic        auto_en = 1'b0;
  logic [11:0] sw;
  logic        auto_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] sw;
    logic        act;
    int          cat;   // 0 idle, 1 sequencing, 2 halted
  } exp_t;

  exp_t expq[$];

  ff_input_ctrl #(
    .DB_CYCLES(DB), .AUTO_DELAY(AD), .PULSE_CYCLES(PC),
    .GAP_CYCLES(GC), .THROW_PERIOD(TP)
  ) dut (
    .clk12m(clk12m), .reset_n(reset_n), .button1(button1), .button2(button2),
    .button3(button3), .js_raw(js_raw), .auto_en(auto_en), .sw(sw),
    .auto_active(auto_active)
  );

  always #5 clk12m = ~clk12m;

  // Reference model: one expectation per rising edge
  initial begin : model
    bit   smp1[8];
    bit   smp2[8];
    bit   dbv[8];
    bit   prv[8];
    int   run[8];
    int   mode;
    int   t;
    bit   rise, gate, coin, start, thr, en_s;
    bit   pin[8];
    exp_t e;
    mode = 0;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      smp1[i] = 0; smp2[i] = 0; dbv[i] = 0; prv[i] = 0; run[i] = 0;
    end
    forever begin
      @(posedge clk12m);
      if (!reset_n) begin
        for (int i = 0; i < 8; i++) begin
          smp1[i] = 0; smp2[i] = 0; dbv[i] = 0; prv[i] = 0; run[i] = 0;
        end
        mode = 0;
        t = 0;
        e.sw = IDLE_SW; e.act = 1'b0; e.cat = 0;
      end else begin
        pin[0] = button1; pin[1] = button2; pin[2] = button3;
        for (int j = 0; j < 4; j++) pin[3+j] = js_raw[j];
        pin[7] = auto_en;
        rise = 0;
        for (int i = 0; i < 7; i++) if (dbv[i] && !prv[i]) rise = 1;
        gate  = (mode == 1) && dbv[7] && !rise;
        coin  = gate && t >= COIN_T && t < COIN_T + PC;
        start = gate && t >= START_T && t < START_T + PC;
        thr   = gate && t >= PLAY_T && ((t - PLAY_T) % TP) < PC;
        e.sw  = {dbv[6], dbv[5], dbv[4], dbv[3], !(dbv[0] || coin), 1'b1,
                 !(dbv[1] || start), 1'b1, 1'b1, !(dbv[2] || thr), 1'b1, 1'b1};
        e.act = (mode == 1) && (t >= COIN_T);
        en_s  = dbv[7];
        if (mode != 0 && !en_s)       mode = 0;
        else if (mode == 1 && rise)   mode = 2;
        else if (mode == 0 && en_s) begin mode = 1; t = 0; end
        else if (mode == 1)           t++;
        for (int i = 0; i < 8; i++) prv[i] = dbv[i];
        // a line's accepted value flips after DB consecutive disagreeing samples
        for (int i = 0; i < 8; i++) begin
          if (smp2[i] != dbv[i]) begin
            run[i]++;
            if (run[i] == ((i == 7) ? 1 : DB)) begin
              dbv[i] = smp2[i];
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
        for (int i = 0; i < 8; i++) begin
          smp2[i] = smp1[i];
          smp1[i] = pin[i];
        end
        e.cat = mode;
      end
      expq.push_back(e);
    end
  end

  // Monitor: compare the DUT against the oldest expectation on every falling edge
  initial begin : monitor
    exp_t e;
    int   dcat;
    forever begin
      @(negedge clk12m);
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = expq.pop_front();
        dcat = (dut.state == ST_IDLE) ? 0 : (dut.state == ST_HALT) ? 2 : 1;
        if (sw !== e.sw || auto_active !== e.act || dcat != e.cat) begin
          errors++;
          $display("FAIL cycle_check at %0t: sw=%h want %h, auto_active=%b want %b, mode=%0d want %0d",
                   $time, sw, e.sw, auto_active, e.act, dcat, e.cat);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk12m);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin : driver
    int found;
    // Reset with random inputs
    reset_n = 1'b0;
    button1 = 1'($urandom); button2 = 1'($urandom); button3 = 1'($urandom);
    js_raw  = 4'($urandom); auto_en = 1'($urandom);
    cyc(4);
    chk("reset_sw", sw, IDLE_SW);
    chk("reset_active", {11'b0, auto_active}, 12'h0);
    button1 = 0; button2 = 0; button3 = 0; js_raw = 0; auto_en = 0;
    reset_n = 1'b1;
    cyc(6);

    // Glitch shorter than the debounce window, then a real press, then joystick
    button1 = 1; cyc(3); button1 = 0; cyc(10);
    button1 = 1; cyc(10); button1 = 0; cyc(10);
    js_raw = 4'b0001; cyc(10); js_raw = 4'b0; cyc(10);

    // Full attract sequence into several throw periods
    auto_en = 1; cyc(80);

    // Manual throw overrides, then re-enable restarts from the full delay
    button3 = 1; cyc(10); button3 = 0; cyc(15);
    auto_en = 0; cyc(6);
    auto_en = 1; cyc(45);

    // Restart and hit reset while START is pressing
    auto_en = 0; cyc(6);
    auto_en = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(1);
      if (sw[SW_START1] === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL start_timeout: start1 never went low within 200 cycles");
    end
    #1 reset_n = 1'b0;
    #1;
    chk("midop_reset_sw", sw, IDLE_SW);
    chk("midop_reset_active", {11'b0, auto_active}, 12'h0);
    chk("midop_reset_state", {9'b0, dut.state}, {9'b0, ST_IDLE});
    cyc(3);
    reset_n = 1'b1;
    cyc(30);

    // auto_en drop lands on the same cycle as a debounced start press
    button2 = 1; cyc(3); auto_en = 0; cyc(10);
    button2 = 0; cyc(10);
    auto_en = 1; cyc(40);

    // Randomised phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 11) == 0)  button1 = ~button1;
      if ($urandom_range(0, 11) == 0)  button2 = ~button2;
      if ($urandom_range(0, 11) == 0)  button3 = ~button3;
      if ($urandom_range(0, 15) == 0)  js_raw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) begin
        button1 = 0; button2 = 0; button3 = 0; js_raw = 0; auto_en = 1;
        cyc(60);
      end
      cyc(1);
    end
    button1 = 0; button2 = 0; button3 = 0; js_raw = 0;
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
